// File: rtl/vga_timing_gen.sv
// VGA raster timing generator with a built-in test-pattern source. Every output
// is registered and reflects the counter state of the previous pix_en cycle.
module vga_timing_gen #(
   parameter int H_ACTIVE = 800,
   parameter int H_FP     = 40,
   parameter int H_SYNC   = 128,
   parameter int H_BP     = 88,
   parameter int V_ACTIVE = 600,
   parameter int V_FP     = 1,
   parameter int V_SYNC   = 4,
   parameter int V_BP     = 23,
   parameter bit H_POL    = 1'b1,
   parameter bit V_POL    = 1'b1,
   parameter int CNT_W    = 12,
   parameter int RGB_W    = 3,
   parameter int CHK_LOG2 = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             pix_en,
   input  logic [1:0]       pattern_sel,
   input  logic [RGB_W-1:0] solid_rgb,
   output logic             h_sync,
   output logic             v_sync,
   output logic             de,
   output logic [CNT_W-1:0] x,
   output logic [CNT_W-1:0] y,
   output logic             line_start,
   output logic             frame_start,
   output logic [RGB_W-1:0] rgb
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int C_W     = RGB_W / 3;
   localparam int BAR_W   = H_ACTIVE / 8;

   // One extra bit so region ends equal to the total never wrap to zero.
   localparam int XW = CNT_W + 1;
   localparam logic [XW-1:0] H_LAST   = XW'(H_TOTAL - 1);
   localparam logic [XW-1:0] V_LAST   = XW'(V_TOTAL - 1);
   localparam logic [XW-1:0] H_ACT_C  = XW'(H_ACTIVE);
   localparam logic [XW-1:0] V_ACT_C  = XW'(V_ACTIVE);
   localparam logic [XW-1:0] H_EDGE   = XW'(H_ACTIVE - 1);
   localparam logic [XW-1:0] V_EDGE   = XW'(V_ACTIVE - 1);
   localparam logic [XW-1:0] HS_BEG   = XW'(H_ACTIVE + H_FP);
   localparam logic [XW-1:0] HS_END   = XW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [XW-1:0] VS_BEG   = XW'(V_ACTIVE + V_FP);
   localparam logic [XW-1:0] VS_END   = XW'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [XW-1:0] BAR_LAST = XW'(BAR_W - 1);

   if (RGB_W == 0 || (RGB_W % 3) != 0) begin : g_bad_rgb_w
      $error("vga_timing_gen: RGB_W must be a non-zero multiple of 3");
   end
   if ((H_TOTAL - 1) >= (2 ** CNT_W) || (V_TOTAL - 1) >= (2 ** CNT_W)) begin : g_bad_cnt_w
      $error("vga_timing_gen: CNT_W too narrow for H_TOTAL-1 / V_TOTAL-1");
   end
   if (H_ACTIVE < 8 || CHK_LOG2 >= CNT_W) begin : g_bad_geom
      $error("vga_timing_gen: H_ACTIVE must be >= 8 and CHK_LOG2 < CNT_W");
   end

   typedef enum logic [1:0] {
      PAT_SOLID   = 2'd0,
      PAT_BARS    = 2'd1,
      PAT_CHECKER = 2'd2,
      PAT_BORDER  = 2'd3
   } pattern_e;

   logic [CNT_W-1:0] h_cnt, v_cnt, h_nxt, v_nxt;
   logic [CNT_W-1:0] bar_pix, bar_pix_nxt;
   logic [2:0]       bar_idx, bar_idx_nxt;
   pattern_e         mode_q, mode_eff;
   logic [XW-1:0]    h_ext, v_ext;
   logic             h_last, v_last, frame_pos, active, hs_on, vs_on, on_edge;
   logic [RGB_W-1:0] pix_rgb;

   // Counter advance and the bar tracker that follows h_cnt.
   // NOTE: every signal assigned here gets a default first, so no latch can be inferred.
   always_comb begin
      h_ext       = {1'b0, h_cnt};
      v_ext       = {1'b0, v_cnt};
      h_last      = (h_ext == H_LAST);
      v_last      = (v_ext == V_LAST);
      h_nxt       = h_last ? '0 : h_cnt + 1'b1;
      v_nxt       = v_cnt;
      bar_pix_nxt = bar_pix + 1'b1;
      bar_idx_nxt = bar_idx;
      if (h_last) begin
         v_nxt       = v_last ? '0 : v_cnt + 1'b1;
         bar_pix_nxt = '0;
         bar_idx_nxt = '0;
      end else if ({1'b0, bar_pix} == BAR_LAST) begin
         bar_pix_nxt = '0;
         bar_idx_nxt = (bar_idx == 3'd7) ? 3'd7 : bar_idx + 3'd1;
      end
   end

   // Decode of the current counter state into region flags and pixel colour.
   always_comb begin
      frame_pos = (h_cnt == '0) && (v_cnt == '0);
      mode_eff  = frame_pos ? pattern_e'(pattern_sel) : mode_q;
      active    = (h_ext < H_ACT_C) && (v_ext < V_ACT_C);
      hs_on     = (h_ext >= HS_BEG) && (h_ext < HS_END);
      vs_on     = (v_ext >= VS_BEG) && (v_ext < VS_END);
      on_edge   = (h_cnt == '0) || (h_ext == H_EDGE) || (v_cnt == '0) || (v_ext == V_EDGE);
      pix_rgb   = '0;
      case (mode_eff)
         PAT_SOLID:   pix_rgb = solid_rgb;
         PAT_BARS:    pix_rgb = {{C_W{bar_idx[2]}}, {C_W{bar_idx[1]}}, {C_W{bar_idx[0]}}};
         PAT_CHECKER: pix_rgb = {RGB_W{h_cnt[CHK_LOG2] ^ v_cnt[CHK_LOG2]}};
         PAT_BORDER:  pix_rgb = on_edge ? {RGB_W{1'b1}} : solid_rgb;
         default:     pix_rgb = '0;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk) begin
      if (!reset) begin
         h_cnt       <= '0;
         v_cnt       <= '0;
         bar_pix     <= '0;
         bar_idx     <= '0;
         mode_q      <= PAT_SOLID;
         h_sync      <= ~H_POL;
         v_sync      <= ~V_POL;
         de          <= 1'b0;
         x           <= '0;
         y           <= '0;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
         rgb         <= '0;
      end else if (pix_en) begin
         h_cnt       <= h_nxt;
         v_cnt       <= v_nxt;
         bar_pix     <= bar_pix_nxt;
         bar_idx     <= bar_idx_nxt;
         mode_q      <= mode_eff;
         h_sync      <= hs_on ? H_POL : ~H_POL;
         v_sync      <= vs_on ? V_POL : ~V_POL;
         de          <= active;
         x           <= active ? h_cnt : '0;
         y           <= active ? v_cnt : '0;
         line_start  <= (h_cnt == '0);
         frame_start <= frame_pos;
         rgb         <= active ? pix_rgb : '0;
      end
   end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen on a 14x8 raster: a cycle model plus
// directed tables for colour bars, pattern latching, pix_en gating and reset.
module tb_vga_timing_gen;

   localparam int HA = 8, HF = 2, HS = 3, HB = 1;
   localparam int VA = 4, VF = 1, VS = 2, VB = 1;
   localparam int CW = 5, RW = 3, CK = 1;
   localparam int HT = 14, VT = 8;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          pix_en = 1'b1;
   logic [1:0]    pattern_sel = 2'd0;
   logic [RW-1:0] solid_rgb = 3'b101;

   logic          hs_a, vs_a, de_a, ls_a, fs_a;
   logic [CW-1:0] x_a, y_a;
   logic [RW-1:0] rgb_a;
   logic          hs_b, vs_b, de_b, ls_b, fs_b;
   logic [CW-1:0] x_b, y_b;
   logic [RW-1:0] rgb_b;

   vga_timing_gen #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
      .H_POL(1'b1), .V_POL(1'b1), .CNT_W(CW), .RGB_W(RW), .CHK_LOG2(CK)
   ) dut_a (
      .clk(clk), .reset(reset), .pix_en(pix_en), .pattern_sel(pattern_sel),
      .solid_rgb(solid_rgb), .h_sync(hs_a), .v_sync(vs_a), .de(de_a), .x(x_a),
      .y(y_a), .line_start(ls_a), .frame_start(fs_a), .rgb(rgb_a)
   );

   vga_timing_gen #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
      .H_POL(1'b0), .V_POL(1'b0), .CNT_W(CW), .RGB_W(RW), .CHK_LOG2(CK)
   ) dut_b (
      .clk(clk), .reset(reset), .pix_en(pix_en), .pattern_sel(pattern_sel),
      .solid_rgb(solid_rgb), .h_sync(hs_b), .v_sync(vs_b), .de(de_b), .x(x_b),
      .y(y_b), .line_start(ls_b), .frame_start(fs_b), .rgb(rgb_b)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference model: counter position and the outputs it should have produced.
   int            mh = 0, mv = 0, last_h = 0, last_v = 0;
   logic [1:0]    mmode = 2'd0;
   logic          e_hs, e_vs, e_de, e_ls, e_fs;
   logic [CW-1:0] e_x, e_y;
   logic [RW-1:0] e_rgb;

   function automatic logic [2:0] rgb_of(input logic [1:0] mode, input int h, input int v,
                                         input logic [2:0] solid);
      int b;
      b = h / (HA / 8);
      if (b > 7) b = 7;
      case (mode)
         2'd0:    return solid;
         2'd1:    return 3'(b);
         2'd2:    return ((((h >> CK) ^ (v >> CK)) & 1) != 0) ? 3'b111 : 3'b000;
         default: return (h == 0 || h == HA - 1 || v == 0 || v == VA - 1) ? 3'b111 : solid;
      endcase
   endfunction

   task automatic model_edge();
      if (!reset) begin
         {e_hs, e_vs, e_de, e_ls, e_fs} = 5'b0;
         e_x = '0; e_y = '0; e_rgb = '0;
         mh = 0; mv = 0; mmode = 2'd0;
      end else if (pix_en) begin
         e_fs = (mh == 0 && mv == 0);
         if (e_fs) mmode = pattern_sel;
         e_de  = (mh < HA) && (mv < VA);
         e_hs  = (mh >= 10) && (mh <= 12);
         e_vs  = (mv >= 5) && (mv <= 6);
         e_ls  = (mh == 0);
         e_x   = e_de ? CW'(mh) : '0;
         e_y   = e_de ? CW'(mv) : '0;
         e_rgb = e_de ? rgb_of(mmode, mh, mv, solid_rgb) : '0;
         last_h = mh; last_v = mv;
         if (mh == HT - 1) begin
            mh = 0;
            mv = (mv == VT - 1) ? 0 : mv + 1;
         end else begin
            mh = mh + 1;
         end
      end
   endtask

   // One clock: update the model at the edge, sample the DUTs 1 time unit later.
   task automatic cyc();
      @(posedge clk);
      model_edge();
      #1;
      check($sformatf("outs_h%0d_v%0d", last_h, last_v),
            {hs_a, vs_a, de_a, x_a, y_a, ls_a, fs_a, rgb_a},
            {e_hs, e_vs, e_de, e_x, e_y, e_ls, e_fs, e_rgb});
      check($sformatf("inv_sync_h%0d_v%0d", last_h, last_v), {hs_b, vs_b}, {~e_hs, ~e_vs});
   endtask

   task automatic run_to(input int th, input int tv, input string tag);
      int n = 0;
      while (!(mh == th && mv == tv) && n < 300) begin
         cyc();
         n++;
      end
      if (!(mh == th && mv == tv)) begin
         n_tests++;
         n_fail++;
         $display("FAIL %s: position (%0d,%0d) not reached within bound", tag, th, tv);
      end
   endtask

   typedef struct packed {
      logic          de;
      logic [CW-1:0] x;
      logic [RW-1:0] rgb;
   } bar_vec_t;

   bar_vec_t bars[HT];

   initial begin
      int fs_cnt, ls_cnt, de_cnt, hs_cnt, vs_cnt, fs_first, fs_second;

      bars = '{'{1'b1, 5'd0, 3'b000}, '{1'b1, 5'd1, 3'b001}, '{1'b1, 5'd2, 3'b010},
               '{1'b1, 5'd3, 3'b011}, '{1'b1, 5'd4, 3'b100}, '{1'b1, 5'd5, 3'b101},
               '{1'b1, 5'd6, 3'b110}, '{1'b1, 5'd7, 3'b111}, '{1'b0, 5'd0, 3'b000},
               '{1'b0, 5'd0, 3'b000}, '{1'b0, 5'd0, 3'b000}, '{1'b0, 5'd0, 3'b000},
               '{1'b0, 5'd0, 3'b000}, '{1'b0, 5'd0, 3'b000}};

      // Reset with pix_en high: reset must win.
      cyc();
      cyc();
      check("reset_outs_pos", {hs_a, vs_a, de_a, x_a, y_a, ls_a, fs_a, rgb_a}, 18'd0);
      check("reset_sync_neg", {hs_b, vs_b}, 2'b11);
      check("reset_outs_neg", {de_b, x_b, y_b, ls_b, fs_b, rgb_b}, 16'd0);
      reset = 1'b1;

      // Two free-running frames in solid mode.
      fs_cnt = 0; ls_cnt = 0; de_cnt = 0; hs_cnt = 0; vs_cnt = 0;
      fs_first = -1; fs_second = -1;
      for (int i = 0; i < 2 * HT * VT; i++) begin
         cyc();
         if (i == 0) check("first_pix", {de_a, x_a, y_a, ls_a, fs_a}, {1'b1, 10'd0, 2'b11});
         if (fs_a) begin
            if (fs_first < 0) fs_first = i;
            else if (fs_second < 0) fs_second = i;
            fs_cnt++;
         end
         ls_cnt += int'(ls_a);
         de_cnt += int'(de_a);
         hs_cnt += int'(hs_a);
         vs_cnt += int'(vs_a);
      end
      check("frame_count", fs_cnt, 2);
      check("frame_period", fs_second - fs_first, 112);
      check("line_count", ls_cnt, 16);
      check("de_count", de_cnt, 64);
      check("hsync_count", hs_cnt, 48);
      check("vsync_count", vs_cnt, 56);

      // pix_en toggling: two frames of enabled cycles, one frame_start per frame.
      fs_cnt = 0;
      for (int i = 0; i < 4 * HT * VT; i++) begin
         pix_en = (i % 2 == 0);
         cyc();
         if (i % 2 == 0) fs_cnt += int'(fs_a);
      end
      pix_en = 1'b1;
      check("gated_frame_count", fs_cnt, 2);

      // Colour bars on line 0 from the table.
      pattern_sel = 2'd1;
      for (int i = 0; i < HT; i++) begin
         cyc();
         check($sformatf("bars_%0d", i), {de_a, x_a, rgb_a}, bars[i]);
      end

      // Latch solid 101, switch to checker mid-frame: no change until frame_start.
      pattern_sel = 2'd0;
      solid_rgb   = 3'b101;
      run_to(0, 0, "to_frame_a");
      cyc();
      run_to(3, 2, "to_mid_frame");
      pattern_sel = 2'd2;
      for (int n = 0; n < 300 && !(mh == 0 && mv == 0); n++) begin
         cyc();
         if (de_a) check($sformatf("solid_hold_x%0d_y%0d", x_a, y_a), rgb_a, 3'b101);
      end
      cyc();
      check("chk_0_0", {fs_a, x_a, y_a, rgb_a}, {1'b1, 5'd0, 5'd0, 3'b000});
      cyc();
      cyc();
      check("chk_2_0", {de_a, x_a, y_a, rgb_a}, {1'b1, 5'd2, 5'd0, 3'b111});
      for (int i = 0; i < 2 * HT; i++) cyc();
      check("chk_2_2", {de_a, x_a, y_a, rgb_a}, {1'b1, 5'd2, 5'd2, 3'b000});

      // Reset in mid-frame at h_cnt=5, v_cnt=2.
      run_to(5, 2, "to_reset_point");
      reset = 1'b0;
      cyc();
      check("midreset_pos", {hs_a, vs_a, de_a, x_a, y_a, ls_a, fs_a, rgb_a}, 18'd0);
      check("midreset_neg_sync", {hs_b, vs_b}, 2'b11);
      reset = 1'b1;
      cyc();
      check("after_release", {de_a, x_a, y_a, ls_a, fs_a}, {1'b1, 10'd0, 2'b11});
      for (int i = 0; i < 4; i++) cyc();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
